// File: rtl/pool_bin_if.sv
// Stream interface for pool_bin: conv results in, binarized pooled bits out.
// raw_max is present only when POOL_RAW_OUT_EN is defined.
interface pool_bin_if #(
  parameter int unsigned DW = 32
);
  logic                 state;
  logic signed [DW-1:0] din;
  logic                 ivalid;
  logic                 idone;
  logic                 dout;
  logic                 ovalid;
  logic                 done;
  logic                 err;
`ifdef POOL_RAW_OUT_EN
  logic signed [DW-1:0] raw_max;

  modport slave  (input  state, din, ivalid, idone,
                  output dout, ovalid, done, err, raw_max);
  modport master (output state, din, ivalid, idone,
                  input  dout, ovalid, done, err, raw_max);
`else
  modport slave  (input  state, din, ivalid, idone,
                  output dout, ovalid, done, err);
  modport master (output state, din, ivalid, idone,
                  input  dout, ovalid, done, err);
`endif
endinterface

// File: rtl/pool_bin.sv
// 2x2 stride-2 signed max pooling over a raster frame, followed by binarization.
// Optional feature macro POOL_RAW_OUT_EN exposes the pooled max on bus.raw_max.
module pool_bin #(
  parameter int unsigned          DW     = 32,
  parameter int unsigned          W0     = 24,
  parameter int unsigned          W1     = 8,
  parameter logic signed [DW-1:0] THRESH = '0
) (
  input logic       clk,
  input logic       rst,
  pool_bin_if.slave bus
);

  localparam int unsigned   CW    = $clog2(W0);
  localparam int unsigned   LD    = W0 / 2;
  localparam logic [CW-1:0] LAST0 = CW'(W0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(W1 - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           fsm, fsm_nxt;
  logic                 sel, sel_nxt;
  logic [CW-1:0]        col, col_nxt;
  logic [CW-1:0]        row, row_nxt;
  logic [CW-1:0]        lim_c;
  logic                 last_c, abort_c, emit_c;
  logic signed [DW-1:0] hold;
  logic signed [DW-1:0] pm_c, lb_c, m_c;
  logic signed [DW-1:0] linebuf [LD];

  // Frame sequencing: W is taken from the live state input only on the beat that leaves IDLE
  always_comb begin
    fsm_nxt = fsm;
    sel_nxt = sel;
    col_nxt = col;
    row_nxt = row;
    last_c  = 1'b0;
    abort_c = 1'b0;
    emit_c  = 1'b0;
    lim_c   = (((fsm == S_IDLE) ? bus.state : sel) != 1'b0) ? LAST1 : LAST0;
    if (bus.ivalid) begin
      if (fsm == S_IDLE) sel_nxt = bus.state;
      last_c  = (row == lim_c) && (col == lim_c);
      abort_c = bus.idone && !last_c;
      emit_c  = row[0] && col[0] && !abort_c;
      if (abort_c || last_c) begin
        fsm_nxt = S_IDLE;
        col_nxt = '0;
        row_nxt = '0;
      end else begin
        fsm_nxt = S_RUN;
        if (col == lim_c) begin
          col_nxt = '0;
          row_nxt = row + CW'(1);
        end else begin
          col_nxt = col + CW'(1);
        end
      end
    end
  end

  // Horizontal pair max, then vertical max against the stored even-row pair
  always_comb begin
    pm_c = (hold > bus.din) ? hold : bus.din;
    lb_c = linebuf[col[CW-1:1]];
    m_c  = (lb_c > pm_c) ? lb_c : pm_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= S_IDLE;
      sel         <= 1'b0;
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      bus.dout    <= 1'b0;
      bus.ovalid  <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
`ifdef POOL_RAW_OUT_EN
      bus.raw_max <= '0;
`endif
    end else begin
      fsm        <= fsm_nxt;
      sel        <= sel_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      bus.ovalid <= emit_c;
      bus.done   <= emit_c && last_c;
      if (bus.ivalid && !col[0]) hold <= bus.din;
      if (emit_c) begin
        bus.dout    <= (m_c >= THRESH);
`ifdef POOL_RAW_OUT_EN
        bus.raw_max <= m_c;
`endif
      end
      if (abort_c) bus.err <= 1'b1;
    end
  end

  // Line buffer is never reset; every slot is written on an even row before its odd-row read
  always_ff @(posedge clk) begin
    if (!rst && bus.ivalid && !row[0] && col[0]) linebuf[col[CW-1:1]] <= pm_c;
  end

endmodule

// File: doc/pool_bin.md
POOL_BIN -- requirements
Module: pool_bin

Interface
REQ-001 SHALL have parameter DW, default 32, width of signed conv result.
REQ-002 SHALL have parameter W0, default 24, frame width/height when state=0.
REQ-003 SHALL have parameter W1, default 8, frame width/height when state=1.
REQ-004 SHALL have parameter THRESH, default 0, signed binarization threshold, DW bits.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- state  in  1  layer select; 0 selects a W0xW0 frame, 1 selects a W1xW1 frame.
- din  in  DW  signed conv result, raster order.
- ivalid  in  1  din valid this cycle.
- idone  in  1  upstream frame-end flag; asserted with the last ivalid of a frame.
- dout  out  1  binarized pooled value.
- ovalid  out  1  dout valid, one-cycle pulse per output.
- done  out  1  asserted together with the last ovalid of a frame.
- err  out  1  sticky frame-length error.

Function
REQ-006 SHALL perform 2x2 stride-2 signed max pooling, then output dout = (max >= THRESH).
REQ-007 SHALL implement FSM IDLE, RUN: IDLE->RUN on the first ivalid; RUN->IDLE after the last pixel (row=W-1, col=W-1) or an early idone.
REQ-008 SHALL latch state on the ivalid that leaves IDLE; W (W0 or W1) stays fixed for the frame, and state changes mid-frame SHALL be ignored.
REQ-009 SHALL keep col (0..W-1) and row (0..W-1) counters, advancing only on ivalid; col wraps to 0 and increments row at W-1.
REQ-010 SHALL ignore din and change nothing when ivalid=0; bubbles of any length SHALL be allowed.
REQ-011 SHALL, at even col, hold din; at odd col, form pm = max(hold, din).
REQ-012 SHALL write pm into a line buffer of W0/2 entries at index col>>1 when row is even.
REQ-013 SHALL compute m = max(linebuf[col>>1], pm) when row is odd, and register the result.
REQ-014 SHALL assert ovalid exactly 1 cycle after each odd-row/odd-col input beat; a frame yields (W/2)^2 outputs in raster order (144 for state=0, 16 for state=1).
REQ-015 SHALL assert done in the same cycle as the final ovalid of the frame.
REQ-016 SHALL set err=1 if idone arrives at any pixel other than the last one; it SHALL then abort the frame, emit no done, and return to IDLE with counters cleared.
REQ-017 SHALL NOT treat a missing idone at the last pixel as an error; the frame completes on the count alone.
REQ-018 SHALL use only signed comparison; -2^(DW-1) and 2^(DW-1)-1 SHALL pool correctly with no overflow.
REQ-019 SHALL accept a new frame's first ivalid in the cycle directly after the last pixel, with no dead cycle.

Reset
REQ-020 SHALL, while rst=1, set dout=0, ovalid=0, done=0, err=0, FSM=IDLE, col=row=0, hold=0.
REQ-021 SHALL leave the line buffer contents unreset; they are never read before being written in a frame.
REQ-022 SHALL let rst asserted mid-frame discard the partial frame; the first ivalid after rst deasserts starts a fresh frame.

Configuration
REQ-023 SHALL, with macro POOL_RAW_OUT_EN defined, add output port raw_max (DW bits, signed), carrying the pooled max m in the same cycle as ovalid and reset to 0.
REQ-024 SHALL, without POOL_RAW_OUT_EN, have no raw_max port, and dout/ovalid/done behaviour SHALL be unchanged.

Verification
REQ-025 Ramp test: state=0, 576 beats, din = (row*24+col)-300 -> 144 ovalids. First output: max=25-300=-275, dout=0. Last output: max=275, dout=1. done coincides with the 144th ovalid.
REQ-026 Small frame: state=1, 64 beats of -5, except pixel (3,5)=7 -> 16 outputs. Only output index 6 (pooled row 1, col 2) has dout=1. done on the 16th output.
REQ-027 Bubbles: repeat REQ-025 with random ivalid gaps of 0-5 cycles -> identical dout sequence, each ovalid exactly 1 cycle after its odd/odd beat.
REQ-028 Early end: idone at beat 100 of a state=0 frame -> err=1 stays set, no done. A following clean state=1 frame -> 16 correct outputs.
REQ-029 Mid-frame reset: rst for 1 cycle at beat 300 -> all outputs 0 the next cycle. A fresh state=0 ramp frame -> matches REQ-025.
REQ-030 Threshold and range: THRESH=0, a 2x2 block of {0,-1,-2^31,-3} -> dout=1. Block {-2^31 x4} -> dout=0. With POOL_RAW_OUT_EN defined, raw_max = 0 and -2^31 respectively.
